// File: rtl/video_pkg.sv
// video_pkg: shared timing defaults, pixel type, FSM states and colour-bar helper
package video_pkg;
  localparam int DEF_HDISP  = 800;
  localparam int DEF_HFP    = 40;
  localparam int DEF_HPULSE = 48;
  localparam int DEF_HBP    = 40;
  localparam int DEF_VDISP  = 480;
  localparam int DEF_VFP    = 13;
  localparam int DEF_VPULSE = 3;
  localparam int DEF_VBP    = 29;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  typedef enum logic {WAIT, RUN} state_t;
  // bar order white, yellow, cyan, green, magenta, red, blue, black
  function automatic rgb_t bar_color(input logic [2:0] i);
    return '{r: {8{~i[1]}}, g: {8{~i[2]}}, b: {8{~i[0]}}};
  endfunction
endpackage

// File: rtl/video_axis_counter.sv
// video_axis_counter: one timing axis (porch/sync/porch/display) with sync, active and wrap flags
module video_axis_counter #(
  parameter int FP    = 40,
  parameter int PULSE = 48,
  parameter int BP    = 40,
  parameter int DISP  = 800,
  parameter int W     = $clog2(FP + PULSE + BP + DISP)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         sync_n,
  output logic         active,
  output logic         wrap
);
  localparam int TOTAL = FP + PULSE + BP + DISP;
  assign wrap   = en && (count == W'(TOTAL - 1));
  assign sync_n = !((count >= W'(FP)) && (count < W'(FP + PULSE)));
  assign active = count >= W'(FP + PULSE + BP);
  // position counter, advances when enabled and wraps at the end of the axis
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (en) count <= wrap ? '0 : count + W'(1);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: TFT timing generator and pixel output stage fed by a show-ahead FIFO (TEST_PATTERN_EN selects colour bars)
module vga_timing_gen
  import video_pkg::*;
#(
  parameter int HDISP  = DEF_HDISP,
  parameter int HFP    = DEF_HFP,
  parameter int HPULSE = DEF_HPULSE,
  parameter int HBP    = DEF_HBP,
  parameter int VDISP  = DEF_VDISP,
  parameter int VFP    = DEF_VFP,
  parameter int VPULSE = DEF_VPULSE,
  parameter int VBP    = DEF_VBP
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst_n,
  input  logic [23:0] pix_data,
  input  logic        pix_empty,
  output logic        pix_rd,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start,
  output logic        underflow
);
  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HBLK   = HFP + HPULSE + HBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic h_sync_n, v_sync_n, h_act, v_act, h_wrap, v_wrap;
  logic active, at_org, udf;
  state_t state_q, state_d;
  rgb_t px_d, px_q;
  video_axis_counter #(.FP(HFP), .PULSE(HPULSE), .BP(HBP), .DISP(HDISP), .W(HW)) u_h (
    .clk(pixel_clk), .rst_n(pixel_rst_n), .en(1'b1),
    .count(h_cnt), .sync_n(h_sync_n), .active(h_act), .wrap(h_wrap)
  );
  video_axis_counter #(.FP(VFP), .PULSE(VPULSE), .BP(VBP), .DISP(VDISP), .W(VW)) u_v (
    .clk(pixel_clk), .rst_n(pixel_rst_n), .en(h_wrap),
    .count(v_cnt), .sync_n(v_sync_n), .active(v_act), .wrap(v_wrap)
  );
  assign active = h_act && v_act;
  // tracks counters == (0,0): true out of reset, then whenever both axes wrap
  always_ff @(posedge pixel_clk or negedge pixel_rst_n)
    if (!pixel_rst_n) at_org <= 1'b1;
    else at_org <= h_wrap && v_wrap;
  // FSM state register
  always_ff @(posedge pixel_clk or negedge pixel_rst_n)
    if (!pixel_rst_n) state_q <= WAIT;
    else state_q <= state_d;
`ifdef TEST_PATTERN_EN
  logic [HW-1:0] x;
  logic [2:0] bar;
  assign x   = h_cnt - HW'(HBLK);
  assign bar = 3'(x / HW'(HDISP / 8));
  // FSM next state: pattern mode never waits for the FIFO
  always_comb state_d = RUN;
  // FSM outputs: colour bars during active display, FIFO untouched
  always_comb begin
    pix_rd = 1'b0;
    udf    = 1'b0;
    px_d   = (state_q == RUN && active) ? bar_color(bar) : '0;
  end
`else
  // FSM next state: join at frame origin with data available, drop out on underflow
  always_comb
    state_d = (state_q == WAIT) ? ((at_org && !pix_empty) ? RUN : WAIT)
                                : ((active && pix_empty) ? WAIT : RUN);
  // FSM outputs: pop and forward the head pixel only when it exists
  always_comb begin
    pix_rd = state_q == RUN && active && !pix_empty;
    udf    = state_q == RUN && active && pix_empty;
    px_d   = pix_rd ? rgb_t'(pix_data) : '0;
  end
`endif
  // output stage: every video output registered from the same counter values
  always_ff @(posedge pixel_clk or negedge pixel_rst_n)
    if (!pixel_rst_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank   <= 1'b0;
      px_q        <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      vga_hs      <= h_sync_n;
      vga_vs      <= v_sync_n;
      vga_blank   <= active;
      px_q        <= px_d;
      frame_start <= at_org;
      underflow   <= underflow | udf;
    end
  assign vga_r = px_q.r;
  assign vga_g = px_q.g;
  assign vga_b = px_q.b;
endmodule
